neuron_mac_array: RTL and testbench
===================================

# neuron_mac_array

Parametrised multi-lane fixed-point neuron engine. It computes LANES dot products in parallel over a streamed input vector: one shared activation per beat, with one weight and one bias per lane. Each result is finished with round-half-up rescaling, a selectable activation and saturation to N bits. It sits between the weight/activation fetch logic and the layer output buffer, and uses valid/ready handshakes on both sides.

## Interface
Parameters:
- N, 16: signed data/weight/result width
- LANES, 4: parallel neurons (≥1)
- ACC_WIDTH, 40: accumulator width (≥2N)
- FRAC, 8: result right-shift (0..ACC_WIDTH-N); FRAC=0 disables rounding
- LEAK_SHIFT, 3: leaky-ReLU negative slope = 2^-LEAK_SHIFT
- CNT_W, 16: beat counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- act_sel  in  2  0 linear, 1 ReLU, 2 leaky ReLU, 3 linear (reserved); sampled on first beat
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted; equals !out_valid || out_ready
- in_first  in  1  beat opens a vector (bias load)
- in_last  in  1  beat closes a vector (result emitted)
- data_i  in  N  signed activation shared by all lanes
- weight_i  in  LANES*N  signed weights; lane k at [k*N +: N]
- bias_i  in  LANES*ACC_WIDTH  signed biases, already at accumulator scale; sampled on first beat
- out_valid  out  1  result register holds a result
- out_ready  in  1  consumer accepts result
- out_data  out  LANES*N  signed results; lane k at [k*N +: N]
- out_sat  out  LANES  per-lane saturation flag for the held result
- out_len  out  CNT_W  number of beats in the held vector (saturates at all-ones)
- err_o  out  1  sticky protocol error
- err_clr  in  1  synchronous clear of err_o

## Operation
- Beat: in_valid && in_ready. All state changes happen on beats only, apart from the output drain and err_clr.
- States: IDLE (no open vector) and ACC (vector open).
- Per lane, on a beat: prod = data_i*weight_k (2N bits), sign-extended to ACC_WIDTH. acc_k <= (in_first ? bias_k : acc_k) + prod. The accumulator wraps modulo 2^ACC_WIDTH; no accumulator saturation.
- IDLE transitions:
  - Beat with in_first and in_last: emit result, stay IDLE.
  - Beat with in_first only: go to ACC, beat_cnt=1.
  - Beat without in_first: ignored (acc, cnt and output unchanged), err_o set.
- ACC transitions:
  - Beat with in_first: restart the vector (bias reload, cnt=1, act_sel re-latched). This is not an error.
  - Beat with in_last: emit result, go to IDLE.
  - Any other beat: cnt+1, saturating.
- Post-processing on the emitting beat, per lane, applied to acc_next:
  - r = (acc_next + 2^(FRAC-1)) >>> FRAC. Arithmetic shift; the rounding term is evaluated at ACC_WIDTH+1 bits so it cannot overflow.
  - a = r; if act=1 and r<0, a=0; if act=2 and r<0, a = r >>> LEAK_SHIFT (floor).
  - out = clamp(a, -2^(N-1), 2^(N-1)-1). out_sat_k = 1 iff clamped.
- Emit: out_data, out_sat and out_len (final cnt) are registered, and out_valid is set. Values stay stable while out_valid && !out_ready.
- Drain: out_valid clears on out_valid && out_ready, unless an emitting beat occurs in the same cycle, in which case the new result loads and out_valid stays 1.
- err_clr has priority over a same-cycle error set.

## Timing
- Reset values: out_valid=0, out_data=0, out_sat=0, out_len=0, err_o=0, state IDLE, acc=0, cnt=0. in_ready=1 during and after reset.
- Reset mid-vector discards the partial vector and any held result.
- Latency: result visible with out_valid=1 in the cycle after the in_last beat's clock edge.
- Throughput: one beat per cycle. Back-to-back single-beat vectors sustain one result per cycle when out_ready=1.
- in_ready is combinational from out_valid/out_ready and is never gated by in_valid. in_valid must not depend on in_ready.
- Beats are stalled whenever the result register is full and not draining, including non-last beats.

## Test plan
- Linear (LANES=4, FRAC=8): bias 0; 3 beats with data=256, weights {256,512,-256,0}, first on beat 0, last on beat 2 -> one cycle later out_data={768,1536,-768,0}, out_sat=0, out_len=3.
- Activations, same stimulus: act_sel=1 -> {768,1536,0,0}; act_sel=2 with LEAK_SHIFT=3 -> {768,1536,-96,0}; act_sel changed mid-vector has no effect.
- Saturation: 4 beats with data=32767 and weight=32767 -> lane 32767, sat=1. With weight=-32768 -> -32768, sat=1. Accumulator wrap check: ACC_WIDTH=2N with a forced overflow yields the modulo result.
- Rounding: single beat (first&last), data=0, bias 128/127/-129/-128 -> out 1/0/-1/0.
- Backpressure: out_ready=0 after vector A -> in_ready=0, vector B beats held, out_data stable for 10 cycles. Raise out_ready together with B's last beat -> A drains and B loads in the same cycle, out_valid stays 1.
- Protocol and reset:
  - Beat without in_first in IDLE -> err_o=1, outputs unchanged; err_clr -> 0.
  - rst_n low mid-vector -> out_valid=0. The next vector's result equals its fresh computation.

Source files
------------

// File: rtl/neuron_mac_array.sv
`default_nettype none
// ============================================================================
// Module      : neuron_mac_array
// Description : LANES parallel fixed-point neurons sharing one streamed
//               activation per beat. Each lane multiply-accumulates
//               data_i * weight_k on top of a per-lane bias. It then
//               rescales with round-half-up, applies linear/ReLU/leaky-ReLU
//               and saturates the result to N bits. Valid/ready on both sides.
// Ports       : clk, rst_n (async, active low)
//               act_sel                  activation select, taken on first beat
//               in_valid/in_ready        input beat handshake
//               in_first/in_last         vector delimiters
//               data_i, weight_i, bias_i activation, per-lane weights/biases
//               out_valid/out_ready      result handshake
//               out_data, out_sat, out_len   held result, clamp flags, beat count
//               err_o/err_clr            sticky protocol error and its clear
// Revision    : 1.0 - initial release
// ============================================================================
module neuron_mac_array #(
    parameter int N          = 16,
    parameter int LANES      = 4,
    parameter int ACC_WIDTH  = 40,
    parameter int FRAC       = 8,
    parameter int LEAK_SHIFT = 3,
    parameter int CNT_W      = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [1:0]                   act_sel,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_first,
    input  logic                         in_last,
    input  logic [N-1:0]                 data_i,
    input  logic [LANES*N-1:0]           weight_i,
    input  logic [LANES*ACC_WIDTH-1:0]   bias_i,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LANES*N-1:0]           out_data,
    output logic [LANES-1:0]             out_sat,
    output logic [CNT_W-1:0]             out_len,
    output logic                         err_o,
    input  logic                         err_clr
);

    // Clamp bounds expressed at the post-shift working width.
    localparam logic signed [ACC_WIDTH:0] c_MAX = {{(ACC_WIDTH+2-N){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] c_MIN = {{(ACC_WIDTH+2-N){1'b1}}, {(N-1){1'b0}}};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_next;
    logic [1:0]           r_act;
    logic [1:0]           w_act;
    logic                 w_beat;
    logic                 w_accept;
    logic                 w_emit;
    logic                 w_err_set;
    logic                 r_out_valid;
    logic [LANES*N-1:0]   r_out_data;
    logic [LANES-1:0]     r_out_sat;
    logic [CNT_W-1:0]     r_out_len;
    logic                 r_err;
    logic [LANES*N-1:0]   w_lane_out;
    logic [LANES-1:0]     w_lane_sat;

    // The result register can take a new result if empty or draining now.
    assign in_ready  = !r_out_valid || out_ready;
    assign w_beat    = in_valid && in_ready;
    // In IDLE only a beat that opens a vector does anything.
    assign w_accept  = w_beat && (in_first || (r_state == ST_ACC));
    assign w_emit    = w_accept && in_last;
    assign w_err_set = w_beat && (r_state == ST_IDLE) && !in_first;
    // The activation of a single-beat vector must use this beat's act_sel.
    assign w_act     = in_first ? act_sel : r_act;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        if (w_accept) begin
            w_state_next = in_last ? ST_IDLE : ST_ACC;
            if (in_first) begin
                w_cnt_next = CNT_W'(1);
            end else if (r_cnt != {CNT_W{1'b1}}) begin
                w_cnt_next = r_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_act   <= 2'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_accept && in_first) begin
                r_act <= act_sel;
            end
        end
    end

    generate
        for (genvar k = 0; k < LANES; k++) begin : g_lane
            logic signed [N-1:0]         w_data_s;
            logic signed [N-1:0]         w_wt;
            logic signed [2*N-1:0]       w_prod;
            logic signed [ACC_WIDTH-1:0] w_prod_ext;
            logic signed [ACC_WIDTH-1:0] w_acc_base;
            logic signed [ACC_WIDTH-1:0] w_acc_next;
            logic signed [ACC_WIDTH-1:0] r_acc;
            logic signed [ACC_WIDTH:0]   w_acc_wide;
            logic signed [ACC_WIDTH:0]   w_r;
            logic signed [ACC_WIDTH:0]   w_leak;
            logic signed [ACC_WIDTH:0]   w_a;
            logic                        w_sat;
            logic [N-1:0]                w_res;

            assign w_data_s   = data_i;
            assign w_wt       = weight_i[k*N +: N];
            assign w_prod     = w_data_s * w_wt;
            assign w_prod_ext = ACC_WIDTH'(w_prod);
            assign w_acc_base = in_first ? $signed(bias_i[k*ACC_WIDTH +: ACC_WIDTH]) : r_acc;
            // Wraps modulo 2^ACC_WIDTH by construction.
            assign w_acc_next = w_acc_base + w_prod_ext;
            // One guard bit so the rounding add cannot overflow.
            assign w_acc_wide = (ACC_WIDTH+1)'(w_acc_next);

            if (FRAC > 0) begin : g_round
                localparam logic signed [ACC_WIDTH:0] c_HALF = (ACC_WIDTH+1)'(1) << (FRAC-1);
                assign w_r = (w_acc_wide + c_HALF) >>> FRAC;
            end else begin : g_no_round
                assign w_r = w_acc_wide;
            end

            assign w_leak = w_r >>> LEAK_SHIFT;

            always_comb begin
                w_a = w_r;
                if (w_r < 0) begin
                    if (w_act == 2'd1) begin
                        w_a = '0;
                    end else if (w_act == 2'd2) begin
                        w_a = w_leak;
                    end
                end
            end

            always_comb begin
                w_sat = 1'b0;
                w_res = w_a[N-1:0];
                if (w_a > c_MAX) begin
                    w_sat = 1'b1;
                    w_res = {1'b0, {(N-1){1'b1}}};
                end else if (w_a < c_MIN) begin
                    w_sat = 1'b1;
                    w_res = {1'b1, {(N-1){1'b0}}};
                end
            end

            assign w_lane_out[k*N +: N] = w_res;
            assign w_lane_sat[k]        = w_sat;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_acc <= '0;
                end else if (w_accept) begin
                    r_acc <= w_acc_next;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sat   <= '0;
            r_out_len   <= '0;
        end else if (w_emit) begin
            // A new result may load in the same cycle the old one drains.
            r_out_valid <= 1'b1;
            r_out_data  <= w_lane_out;
            r_out_sat   <= w_lane_sat;
            r_out_len   <= w_cnt_next;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (err_clr) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sat   = r_out_sat;
    assign out_len   = r_out_len;
    assign err_o     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_neuron_mac_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_neuron_mac_array
// Description : Directed self-checking bench for neuron_mac_array. A second
//               instance with ACC_WIDTH = 2N exercises accumulator wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_neuron_mac_array;

    localparam int N     = 16;
    localparam int LANES = 4;
    localparam int ACC   = 40;
    localparam int ACCW  = 32;
    localparam int FRAC  = 8;
    localparam int LS    = 3;
    localparam int CW    = 16;

    logic                   clk;
    logic                   rst_n;
    logic [1:0]             act_sel;
    logic                   in_valid;
    logic                   in_ready;
    logic                   in_first;
    logic                   in_last;
    logic [N-1:0]           data_i;
    logic [LANES*N-1:0]     weight_i;
    logic [LANES*ACC-1:0]   bias_i;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*N-1:0]     out_data;
    logic [LANES-1:0]       out_sat;
    logic [CW-1:0]          out_len;
    logic                   err_o;
    logic                   err_clr;

    logic [LANES*ACCW-1:0]  bias_w;
    logic                   in_ready_w;
    logic                   out_valid_w;
    logic [LANES*N-1:0]     out_data_w;
    logic [LANES-1:0]       out_sat_w;
    logic [CW-1:0]          out_len_w;
    logic                   err_o_w;

    neuron_mac_array #(
        .N(N), .LANES(LANES), .ACC_WIDTH(ACC), .FRAC(FRAC), .LEAK_SHIFT(LS), .CNT_W(CW)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .act_sel(act_sel),
        .in_valid(in_valid), .in_ready(in_ready), .in_first(in_first), .in_last(in_last),
        .data_i(data_i), .weight_i(weight_i), .bias_i(bias_i),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sat(out_sat), .out_len(out_len), .err_o(err_o), .err_clr(err_clr)
    );

    neuron_mac_array #(
        .N(N), .LANES(LANES), .ACC_WIDTH(ACCW), .FRAC(FRAC), .LEAK_SHIFT(LS), .CNT_W(CW)
    ) u_dut_wrap (
        .clk(clk), .rst_n(rst_n), .act_sel(act_sel),
        .in_valid(in_valid), .in_ready(in_ready_w), .in_first(in_first), .in_last(in_last),
        .data_i(data_i), .weight_i(weight_i), .bias_i(bias_w),
        .out_valid(out_valid_w), .out_ready(out_ready), .out_data(out_data_w),
        .out_sat(out_sat_w), .out_len(out_len_w), .err_o(err_o_w), .err_clr(err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [LANES*N-1:0] pk(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    function automatic logic [LANES*ACC-1:0] pkb(input int a, input int b, input int c, input int d);
        return {40'(d), 40'(c), 40'(b), 40'(a)};
    endfunction

    // Streams nb beats back to back; returns #1 after the last beat's edge.
    task automatic run_vec(input int nb, input logic [N-1:0] d, input logic [LANES*N-1:0] w,
                           input logic [LANES*ACC-1:0] b, input logic [1:0] act0,
                           input logic [1:0] actr);
        for (int i = 0; i < nb; i++) begin
            in_valid = 1'b1;
            in_first = (i == 0);
            in_last  = (i == nb - 1);
            data_i   = d;
            weight_i = w;
            bias_i   = (i == 0) ? b : pkb(999, 999, 999, 999);
            act_sel  = (i == 0) ? act0 : actr;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    logic [LANES*N-1:0] w_a;
    logic [LANES*N-1:0] exp_a;

    initial begin
        rst_n = 1'b0; act_sel = 2'd0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        data_i = '0; weight_i = '0; bias_i = '0; bias_w = '0; out_ready = 1'b1; err_clr = 1'b0;
        w_a   = pk(256, 512, -256, 0);
        exp_a = pk(768, 1536, -768, 0);

        step; step;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        check("rst_sat", 64'(out_sat), 64'd0);
        check("rst_len", 64'(out_len), 64'd0);
        check("rst_err", 64'(err_o), 64'd0);
        rst_n = 1'b1;
        step;

        // Linear
        run_vec(3, 16'd256, w_a, '0, 2'd0, 2'd0);
        check("lin_valid", 64'(out_valid), 64'd1);
        check("lin_data", 64'(out_data), 64'(exp_a));
        check("lin_sat", 64'(out_sat), 64'd0);
        check("lin_len", 64'(out_len), 64'd3);
        step;
        check("lin_drain", 64'(out_valid), 64'd0);

        // ReLU
        run_vec(3, 16'd256, w_a, '0, 2'd1, 2'd1);
        check("relu_data", 64'(out_data), 64'(pk(768, 1536, 0, 0)));
        step;

        // Leaky ReLU, act_sel dropped to linear after the first beat
        run_vec(3, 16'd256, w_a, '0, 2'd2, 2'd0);
        check("leaky_data", 64'(out_data), 64'(pk(768, 1536, -96, 0)));
        step;

        // Positive and negative saturation
        run_vec(4, 16'd32767, pk(32767, 32767, 32767, 32767), '0, 2'd0, 2'd0);
        check("satp_data", 64'(out_data), 64'(pk(32767, 32767, 32767, 32767)));
        check("satp_sat", 64'(out_sat), 64'hF);
        check("satp_len", 64'(out_len), 64'd4);
        step;
        run_vec(4, 16'd32767, pk(-32768, -32768, -32768, -32768), '0, 2'd0, 2'd0);
        check("satn_data", 64'(out_data), 64'(pk(-32768, -32768, -32768, -32768)));
        check("satn_sat", 64'(out_sat), 64'hF);
        step;

        // Rounding on a single-beat vector
        run_vec(1, 16'd0, '0, pkb(128, 127, -129, -128), 2'd0, 2'd0);
        check("rnd_data", 64'(out_data), 64'(pk(1, 0, -1, 0)));
        check("rnd_sat", 64'(out_sat), 64'd0);
        check("rnd_len", 64'(out_len), 64'd1);
        step;

        // Accumulator wrap at ACC_WIDTH = 2N: 0x7FFFFFFF + 1 wraps negative
        bias_w = {32'd0, 32'd0, 32'd0, 32'h7FFF_FFFF};
        run_vec(1, 16'd1, pk(1, 0, 0, 0), '0, 2'd0, 2'd0);
        check("wrap_data", 64'(out_data_w), 64'(pk(-32768, 0, 0, 0)));
        check("wrap_sat", 64'(out_sat_w), 64'h1);
        bias_w = '0;
        step;

        // Backpressure: A held, B stalled, then A drains while B loads
        out_ready = 1'b0;
        run_vec(3, 16'd256, w_a, '0, 2'd0, 2'd0);
        check("bp_a_valid", 64'(out_valid), 64'd1);
        in_valid = 1'b1; in_first = 1'b1; in_last = 1'b1; data_i = 16'd256;
        weight_i = pk(512, 512, 512, 512); bias_i = '0; act_sel = 2'd0;
        for (int i = 0; i < 10; i++) begin
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_hold", 64'(out_data), 64'(exp_a));
            step;
        end
        out_ready = 1'b1;
        #1;
        check("bp_ready_up", 64'(in_ready), 64'd1);
        step;
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        check("bp_b_valid", 64'(out_valid), 64'd1);
        check("bp_b_data", 64'(out_data), 64'(pk(512, 512, 512, 512)));
        check("bp_b_len", 64'(out_len), 64'd1);
        step;
        check("bp_drain", 64'(out_valid), 64'd0);

        // Protocol error: non-first beat in IDLE is ignored
        in_valid = 1'b1; in_first = 1'b0; in_last = 1'b1; weight_i = pk(1, 1, 1, 1);
        step;
        in_valid = 1'b0; in_last = 1'b0;
        check("err_set", 64'(err_o), 64'd1);
        check("err_no_emit", 64'(out_valid), 64'd0);
        check("err_data_kept", 64'(out_data), 64'(pk(512, 512, 512, 512)));
        err_clr = 1'b1;
        step;
        err_clr = 1'b0;
        check("err_clr", 64'(err_o), 64'd0);

        // Reset discards a held result
        out_ready = 1'b0;
        run_vec(3, 16'd256, w_a, '0, 2'd0, 2'd0);
        check("rst_pre_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst_async_valid", 64'(out_valid), 64'd0);
        check("rst_async_data", 64'(out_data), 64'd0);
        check("rst_async_ready", 64'(in_ready), 64'd1);
        step;
        rst_n = 1'b1; out_ready = 1'b1;
        step;

        // Reset mid-vector returns to IDLE
        in_valid = 1'b1; in_first = 1'b1; in_last = 1'b0; data_i = 16'd256; weight_i = w_a;
        step;
        in_first = 1'b0;
        step;
        in_valid = 1'b0;
        rst_n = 1'b0;
        step;
        rst_n = 1'b1;
        step;
        in_valid = 1'b1; in_first = 1'b0; in_last = 1'b1;
        step;
        in_valid = 1'b0; in_last = 1'b0;
        check("rst_mid_err", 64'(err_o), 64'd1);
        check("rst_mid_noemit", 64'(out_valid), 64'd0);
        err_clr = 1'b1;
        step;
        err_clr = 1'b0;
        run_vec(3, 16'd256, w_a, '0, 2'd0, 2'd0);
        check("rst_fresh_data", 64'(out_data), 64'(exp_a));
        check("rst_fresh_len", 64'(out_len), 64'd3);
        step;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
